// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider, signed/unsigned, result {remainder, quotient}.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor finishes in two cycles with a zero result.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic        start_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] dvd;    // dividend magnitude, shifts out MSB-first while quotient bits shift in
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        neg_q, neg_r;

  logic [31:0] mag_a, mag_b;
  logic [32:0] trial;
  logic        take;
  logic [31:0] rem_nxt;
  logic [31:0] q_fix, r_fix;
  logic        zero_short;

  assign mag_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Restoring step; trial never exceeds 33 bits, and a taken subtraction always fits in 32.
  assign trial   = {rem, dvd[31]};
  assign take    = (trial >= {1'b0, dvs});
  assign rem_nxt = take ? (trial[31:0] - dvs) : trial[31:0];

  assign q_fix = neg_q ? (~dvd + 32'd1) : dvd;
  assign r_fix = neg_r ? (~rem + 32'd1) : rem;

`ifdef DIV_ZERO_SHORTCUT_EN
  assign zero_short = (opdata2_i == 32'd0);
`else
  assign zero_short = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      dvd      <= 32'd0;
      dvs      <= 32'd0;
      rem      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (zero_short) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              cnt   <= 6'd0;
              rem   <= 32'd0;
              dvd   <= mag_a;
              dvs   <= mag_b;
              neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_r <= signed_div_i & opdata1_i[31];
            end
          end
        end
        BYZERO: begin
          state <= END;
          dvd   <= 32'd0;
          rem   <= 32'd0;
        end
        ON: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (annul_i) begin
            state <= FREE;
            cnt   <= 6'd0;
            dvd   <= 32'd0;
            dvs   <= 32'd0;
            rem   <= 32'd0;
          end else if (cnt != 6'd32) begin
            dvd <= {dvd[30:0], take};
            rem <= rem_nxt;
            cnt <= cnt + 6'd1;
          end else begin
            // Sign correction in place; dvd/rem then hold the final quotient/remainder.
            dvd   <= q_fix;
            rem   <= r_fix;
            cnt   <= 6'd0;
            state <= END;
          end
        end
        END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= {rem, dvd};
          end else begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus hand sequences for annul, reset and operand hold.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic        start_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .start_i(start_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Edge i=0 is the first rising edge after entry; holds start until ready, then drops it.
  task automatic wait_done(input string nm, input logic [63:0] exp, input int lat);
    int e;
    e = -1;
    for (int i = 0; i <= 45; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin e = i; break; end
    end
    chk({nm, "_lat"}, 64'(e), 64'(lat));
    chk({nm, "_res"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_clr"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  task automatic run_vec(input string nm, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    wait_done(nm, exp, lat);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                  34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},     34};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0, 32'h80000000},            34};
`ifdef DIV_ZERO_SHORTCUT_EN
    vecs[3]  = '{1'b0, 32'h12345678,   32'd0,        64'd0,                            2};
    vecs[11] = '{1'b1, 32'hFFFFFFFB,   32'd0,        64'd0,                            2};
`else
    vecs[3]  = '{1'b0, 32'h12345678,   32'd0,        {32'h12345678, 32'hFFFFFFFF},     34};
    vecs[11] = '{1'b1, 32'hFFFFFFFB,   32'd0,        {32'hFFFFFFFB, 32'd1},            34};
`endif
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0, 32'hFFFFFFFF},            34};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},            34};
    vecs[6]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},           34};
    vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'd0},            34};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,       {32'd5, 32'd0},                   34};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, {32'd0, 32'd1},                   34};
    vecs[10] = '{1'b1, 32'h80000000,   32'd1,        {32'd0, 32'h80000000},            34};
    vecs[12] = '{1'b0, 32'd1000000,    32'd1000,     {32'd0, 32'd1000},                34};

    rst = 1'b1; signed_div_i = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    #1;
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Annul at step 10 of 20/3 while start stays high; 9/3 then restarts from scratch.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    @(posedge clk); #1;
    chk("annul_clr", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    wait_done("annul_9_3", {32'd0, 32'd3}, 34);

    // Annul while FREE blocks the start until it is released.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    wait_done("annul_free", {32'd2, 32'd14}, 34);

    // Operand changes mid-division are ignored; edge i=0 here is N+6.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    wait_done("op_hold", {32'd2, 32'd14}, 28);

    // Reset between edges mid-division, then a fresh 5/5.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_on_clr", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    run_vec("after_rst", 1'b0, 32'd5, 32'd5, {32'd0, 32'd1}, 34);

    // Reset while holding a valid result clears the outputs without a clock edge.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) break;
    end
    chk("end_ready", {63'd0, ready_o}, 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
